// File: rtl/ha1_task4.sv
// ha1_task4: mod-26 Caesar encoder; in clk, rst_n, P[4:0], K[4:0]; out C=(P+K)%26, err=(P|K>25), C_q/err_q registered copies
module ha1_task4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] P,
    input  logic [4:0] K,
    output logic [4:0] C,
    output logic       err,
    output logic [4:0] C_q,
    output logic       err_q
);
    logic [5:0] s, s1, s2;
    always_comb begin
        s   = {1'b0, P} + {1'b0, K};
        s1  = s >= 6'd26 ? s - 6'd26 : s;
        s2  = s1 >= 6'd26 ? s1 - 6'd26 : s1;
        C   = s2[4:0];
        err = (P > 5'd25) || (K > 5'd25);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            C_q   <= '0;
            err_q <= 1'b0;
        end else begin
            C_q   <= C;
            err_q <= err;
        end
endmodule

// File: tb/tb_ha1_task4.sv
// tb_ha1_task4: scoreboard bench for ha1_task4 against an arithmetic mod-26 model
`timescale 1ns/100ps
module tb_ha1_task4;
    typedef struct packed {
        logic [4:0] c;
        logic       e;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] P = '0;
    logic [4:0] K = '0;
    logic [4:0] C, C_q;
    logic       err, err_q;
    int         checks = 0;
    int         errors = 0;
    exp_t       comb_q[$];
    exp_t       reg_q[$];
    event       go;
    ha1_task4 dut (
        .clk(clk), .rst_n(rst_n), .P(P), .K(K),
        .C(C), .err(err), .C_q(C_q), .err_q(err_q)
    );
    always #5 clk = ~clk;
    function automatic exp_t model(input int p, input int k);
        exp_t r;
        r.c = 5'((p + k) % 26);
        r.e = (p > 25) || (k > 25);
        return r;
    endfunction
    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, req);
        end
    endtask
    task automatic apply(input int p, input int k);
        @(negedge clk);
        #1;
        P = 5'(p);
        K = 5'(k);
        comb_q.push_back(model(p, k));
        ->go;
    endtask
    initial forever begin
        exp_t x;
        @(go);
        #9;
        x = comb_q.pop_front();
        check($sformatf("C(P=%0d,K=%0d)", P, K), C, x.c);
        check($sformatf("err(P=%0d,K=%0d)", P, K), err, x.e);
    end
    always @(posedge clk) reg_q.push_back(rst_n ? model(P, K) : exp_t'(0));
    always @(negedge clk) begin
        exp_t x;
        if (reg_q.size() > 0) begin
            x = reg_q.pop_front();
            if (!rst_n) x = '0;
            check("C_q", C_q, x.c);
            check("err_q", err_q, x.e);
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        #1;
        check("reset C_q", C_q, 0);
        check("reset err_q", err_q, 0);
        #2 rst_n = 1'b1;
        for (int p = 0; p < 26; p++)
            for (int k = 0; k < 26; k++)
                apply(p, k);
        apply(25, 0);
        apply(25, 1);
        apply(13, 13);
        apply(25, 25);
        apply(31, 0);
        apply(31, 31);
        apply(0, 26);
        for (int p = 0; p < 26; p++) apply(p, 0);
        apply(3, 4);
        apply(20, 10);
        #1 check("C_q holds before edge", C_q, 7);
        apply(3, 4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset C_q", C_q, 0);
        check("async reset err_q", err_q, 0);
        check("C during reset", C, 7);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("C_q before reload", C_q, 0);
        @(posedge clk);
        #1 check("C_q reload", C_q, 7);
        apply(31, 2);
        for (int i = 0; i < 200; i++) apply($urandom_range(0, 31), $urandom_range(0, 31));
        repeat (3) @(negedge clk);
        check("comb queue drained", comb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
